internal_ram_arbiter: RTL and testbench
=======================================

# internal_ram_arbiter

Two-port arbiter that shares the single-port internal RAM (4096 x 32, byte-masked, 1-cycle read latency, lower 1024 words are ROM) between two requesters: port A (CPU instruction/data bus) and port B (debug/DMA loader). It grants at most one command per cycle to the RAM using round-robin priority. It routes read data back to the issuing port and blocks writes into the ROM window. It also inserts a bubble on write-then-read to the same word, so a read never returns stale data.

## Interface
- ROM_WORDS, 1024, number of low words that are read-only; writes below this address are dropped.
- ERR_CNT_W, 8, width of the saturating ROM-write-violation counter.
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_cmd_valid  in  1  port A command present.
- a_cmd_ready  out  1  port A command accepted this cycle.
- a_cmd_wr  in  1  1 = write, 0 = read.
- a_cmd_addr  in  12  word address.
- a_cmd_mask  in  4  byte enables (write only).
- a_cmd_data  in  32  write data.
- a_rsp_valid  out  1  port A read data valid.
- a_rsp_data  out  32  port A read data.
- b_cmd_valid, b_cmd_ready, b_cmd_wr, b_cmd_addr, b_cmd_mask, b_cmd_data, b_rsp_valid, b_rsp_data: identical to port A, for port B.
- ram_en  out  1  RAM clock enable.
- ram_wr  out  1  RAM write strobe.
- ram_addr  out  12  RAM address.
- ram_mask  out  4  RAM byte mask.
- ram_wrData  out  32  RAM write data.
- ram_rdData  in  32  RAM read data, valid one cycle after ram_en with ram_wr=0.
- rom_wr_err  out  1  one-cycle pulse when an accepted write targets address < ROM_WORDS.
- rom_wr_err_cnt  out  ERR_CNT_W  saturating count of such writes.

## Operation
- Arbitration is combinational within the cycle and depends on the valid inputs and the state registers. cmd_ready may depend on the same port's cmd_valid; requesters must not make cmd_valid depend on cmd_ready.
- Grant rules:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port not granted last; last_grant updates only on an actual grant.
- Only the granted port sees cmd_ready=1. A port holds its command stable until it sees ready.
- The granted command drives ram_en=1 and ram_addr, ram_mask and ram_wrData from the winner.
  - ram_wr = winner.wr & (addr >= ROM_WORDS).
  - With no grant, ram_en=0 and ram_wr=0. ram_addr, ram_mask and ram_wrData are don't-care.
- ROM protection: an accepted write with addr < ROM_WORDS still handshakes (ready=1) but is dropped. That cycle asserts rom_wr_err=1, and the counter increments and saturates at all-ones.
- Hazard bubble: registers prev_wr (an effective write was issued last cycle) and prev_addr.
  - Condition: prev_wr=1 and the would-be winner is a read with addr == prev_addr.
  - Action: no grant, both readies 0, ram_en=0, last_grant unchanged.
  - Dropped ROM writes do not set prev_wr.
- Read return: registers pend_a and pend_b capture which port issued a read.
  - Next cycle: x_rsp_valid = pend_x, and x_rsp_data = ram_rdData (passthrough, no register).
  - rsp_data of the non-pending port is don't-care. Responses cannot be back-pressured.
- Writes generate no response.

## Timing
- Read accepted in cycle N: rsp_valid high in cycle N+1 only, with the data of that address.
- Back-to-back reads (any port mix) sustain one per cycle; responses return in issue order.
- Write accepted in cycle N: a read of the same word is first grantable in cycle N+2. A read of a different word is grantable in cycle N+1.
- Reset values (async on reset_n=0, held until release):
  - a_cmd_ready = b_cmd_ready = 0, as long as reset is asserted.
  - a_rsp_valid = b_rsp_valid = 0.
  - ram_en = ram_wr = 0.
  - rom_wr_err = 0, rom_wr_err_cnt = 0.
  - last_grant = B, so A wins the first tie.
  - prev_wr = 0, pend_a = pend_b = 0.
- Reset mid-transaction: pending responses are discarded; no rsp_valid appears after reset release for pre-reset reads.
- Address wrap: no arithmetic on addresses; 12'hFFF is an ordinary RAM word, 12'h3FF is the last ROM word and 12'h400 is the first writable word (ROM_WORDS=1024).

## Test plan
- Reset, then A reads 0x000 with RAM word 0x000 = 0x12345678: a_cmd_ready=1 in cycle N, a_rsp_valid=1 with a_rsp_data=0x12345678 in N+1, b_rsp_valid stays 0.
- A and B continuously valid reads for 6 cycles: grants alternate A,B,A,B,A,B. Six responses arrive on the matching ports one cycle after each grant, and ram_en is high every cycle.
- B writes 0xDEADBEEF, mask 4'b1111 to 0x400, and A reads 0x400 in the next cycle: one bubble cycle (both readies 0, ram_en=0), then A granted. a_rsp_data=0xDEADBEEF.
- A writes to 0x3FF (ROM) 300 times: every write handshakes, ram_wr=0 throughout, rom_wr_err pulses 300 times, rom_wr_err_cnt saturates at 255, and ROM content is unchanged on readback.
- B write 0x400 with mask 4'b0010, data 0x0000AB00, over prior 0x11223344: readback gives 0x1122AB44.
- Assert reset_n low for the cycle after an A read is accepted, then release: no a_rsp_valid occurs, all outputs are 0 during reset, and the first tie after release goes to A.

Source files
------------

// File: rtl/internal_ram_arbiter_if.sv
// Bundle of the two requester ports, the RAM port and the ROM-violation
// status of internal_ram_arbiter. The arbiter uses the slave view; the
// requesters together with the RAM macro use the master view.
interface internal_ram_arbiter_if #(
   parameter int unsigned ERR_CNT_W = 8
);
   // port A (CPU instruction/data bus)
   logic                 a_cmd_valid;
   logic                 a_cmd_ready;
   logic                 a_cmd_wr;
   logic [11:0]          a_cmd_addr;
   logic [3:0]           a_cmd_mask;
   logic [31:0]          a_cmd_data;
   logic                 a_rsp_valid;
   logic [31:0]          a_rsp_data;

   // port B (debug/DMA loader)
   logic                 b_cmd_valid;
   logic                 b_cmd_ready;
   logic                 b_cmd_wr;
   logic [11:0]          b_cmd_addr;
   logic [3:0]           b_cmd_mask;
   logic [31:0]          b_cmd_data;
   logic                 b_rsp_valid;
   logic [31:0]          b_rsp_data;

   // single-port RAM
   logic                 ram_en;
   logic                 ram_wr;
   logic [11:0]          ram_addr;
   logic [3:0]           ram_mask;
   logic [31:0]          ram_wrData;
   logic [31:0]          ram_rdData;

   // ROM write protection status
   logic                 rom_wr_err;
   logic [ERR_CNT_W-1:0] rom_wr_err_cnt;

   modport slave (
      input  a_cmd_valid, a_cmd_wr, a_cmd_addr, a_cmd_mask, a_cmd_data,
      output a_cmd_ready, a_rsp_valid, a_rsp_data,
      input  b_cmd_valid, b_cmd_wr, b_cmd_addr, b_cmd_mask, b_cmd_data,
      output b_cmd_ready, b_rsp_valid, b_rsp_data,
      output ram_en, ram_wr, ram_addr, ram_mask, ram_wrData,
      input  ram_rdData,
      output rom_wr_err, rom_wr_err_cnt
   );

   modport master (
      output a_cmd_valid, a_cmd_wr, a_cmd_addr, a_cmd_mask, a_cmd_data,
      input  a_cmd_ready, a_rsp_valid, a_rsp_data,
      output b_cmd_valid, b_cmd_wr, b_cmd_addr, b_cmd_mask, b_cmd_data,
      input  b_cmd_ready, b_rsp_valid, b_rsp_data,
      input  ram_en, ram_wr, ram_addr, ram_mask, ram_wrData,
      output ram_rdData,
      input  rom_wr_err, rom_wr_err_cnt
   );
endinterface

// File: rtl/internal_ram_arbiter.sv
// Round-robin arbiter sharing the single-port 4096x32 internal RAM between
// port A (CPU) and port B (debug/DMA). One command per cycle reaches the RAM.
// Writes into the low ROM_WORDS words handshake but are dropped and counted.
// A read of the word written in the previous cycle is held back one cycle so
// it never observes pre-write data. Read data is routed back, unregistered,
// to the port that issued the read.
module internal_ram_arbiter #(
   parameter int unsigned ROM_WORDS = 1024,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   internal_ram_arbiter_if.slave arb
);

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

   // 13 bits so ROM_WORDS = 4096 (whole RAM read-only) stays representable
   localparam logic [12:0] ROM_LIMIT = 13'(ROM_WORDS);

   // state
   grant_e               last_grant_q, last_grant_d;
   logic                 prev_wr_q,    prev_wr_d;
   logic [11:0]          prev_addr_q,  prev_addr_d;
   logic                 pend_a_q,     pend_a_d;
   logic                 pend_b_q,     pend_b_d;
   logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

   // arbitration
   logic        any_valid;
   logic        sel_a;
   logic        win_wr;
   logic [11:0] win_addr;
   logic [3:0]  win_mask;
   logic [31:0] win_data;
   logic        in_rom;
   logic        hazard;
   logic        grant;
   logic        eff_wr;
   logic        rom_err;

   // Pick the would-be winner, then veto it on a write-then-read hazard.
   // reset_n gates the grant so no handshake is offered while in reset.
   always_comb begin
      any_valid = arb.a_cmd_valid | arb.b_cmd_valid;
      sel_a     = 1'b0;
      if (arb.a_cmd_valid && arb.b_cmd_valid) begin
         sel_a = (last_grant_q == GNT_B);
      end else begin
         sel_a = arb.a_cmd_valid;
      end

      win_wr   = sel_a ? arb.a_cmd_wr   : arb.b_cmd_wr;
      win_addr = sel_a ? arb.a_cmd_addr : arb.b_cmd_addr;
      win_mask = sel_a ? arb.a_cmd_mask : arb.b_cmd_mask;
      win_data = sel_a ? arb.a_cmd_data : arb.b_cmd_data;

      in_rom  = ({1'b0, win_addr} < ROM_LIMIT);
      hazard  = prev_wr_q & ~win_wr & (win_addr == prev_addr_q);
      grant   = reset_n & any_valid & ~hazard;
      eff_wr  = grant & win_wr & ~in_rom;
      rom_err = grant & win_wr & in_rom;
   end

   // Next-state values for grant history, hazard tracking, read routing and
   // the saturating ROM-violation counter.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant) begin
         last_grant_d = sel_a ? GNT_A : GNT_B;
      end

      // only writes that really reach the RAM can create a hazard
      prev_wr_d   = eff_wr;
      prev_addr_d = win_addr;

      pend_a_d = grant &  sel_a & ~win_wr;
      pend_b_d = grant & ~sel_a & ~win_wr;

      err_cnt_d = err_cnt_q;
      if (rom_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   // State registers; reset discards any in-flight read response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= GNT_B;
         prev_wr_q    <= 1'b0;
         prev_addr_q  <= '0;
         pend_a_q     <= 1'b0;
         pend_b_q     <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         prev_wr_q    <= prev_wr_d;
         prev_addr_q  <= prev_addr_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // handshakes
   assign arb.a_cmd_ready = grant &  sel_a;
   assign arb.b_cmd_ready = grant & ~sel_a;

   // RAM command; address/mask/data forced to zero when idle
   assign arb.ram_en     = grant;
   assign arb.ram_wr     = eff_wr;
   assign arb.ram_addr   = grant ? win_addr : '0;
   assign arb.ram_mask   = grant ? win_mask : '0;
   assign arb.ram_wrData = grant ? win_data : '0;

   // read responses: RAM output passes straight through to the pending port
   assign arb.a_rsp_valid = pend_a_q;
   assign arb.b_rsp_valid = pend_b_q;
   assign arb.a_rsp_data  = pend_a_q ? arb.ram_rdData : '0;
   assign arb.b_rsp_data  = pend_b_q ? arb.ram_rdData : '0;

   // ROM protection status
   assign arb.rom_wr_err     = rom_err;
   assign arb.rom_wr_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_internal_ram_arbiter.sv
// Directed bench for internal_ram_arbiter with a behavioural 4096x32
// byte-masked RAM (1-cycle read latency). Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_internal_ram_arbiter;

   logic clk;
   logic reset_n;

   internal_ram_arbiter_if #(.ERR_CNT_W(8)) arb();

   internal_ram_arbiter #(
      .ROM_WORDS (1024),
      .ERR_CNT_W (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .arb     (arb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural RAM
   logic [31:0] mem [0:4095];

   // RAM model: byte-masked write, registered read
   always @(posedge clk) begin
      if (arb.ram_en) begin
         if (arb.ram_wr) begin
            for (int b = 0; b < 4; b++) begin
               if (arb.ram_mask[b]) mem[arb.ram_addr][b*8 +: 8] = arb.ram_wrData[b*8 +: 8];
            end
         end else begin
            arb.ram_rdData <= mem[arb.ram_addr];
         end
      end
   end

   int n_cmp;
   int n_bad;
   int n_rdy;
   int n_pulse;
   int n_ramwr;

   logic [11:0] aa;
   logic [11:0] ba;
   logic [11:0] last_addr;
   logic        a_turn;
   logic        last_a;

   function automatic logic [31:0] pat(input logic [11:0] a);
      return {20'h5A5A5, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmd_a(input logic v, input logic wr, input logic [11:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
      arb.a_cmd_valid = v;
      arb.a_cmd_wr    = wr;
      arb.a_cmd_addr  = addr;
      arb.a_cmd_mask  = mask;
      arb.a_cmd_data  = data;
   endtask

   task automatic cmd_b(input logic v, input logic wr, input logic [11:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
      arb.b_cmd_valid = v;
      arb.b_cmd_wr    = wr;
      arb.b_cmd_addr  = addr;
      arb.b_cmd_mask  = mask;
      arb.b_cmd_data  = data;
   endtask

   task automatic idle();
      cmd_a(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
      cmd_b(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
      mem[0] = 32'h12345678;

      // ---- reset: both ports requesting, nothing may be offered
      reset_n = 1'b0;
      cmd_a(1'b1, 1'b0, 12'h000, 4'h0, 32'h0);
      cmd_b(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_a_rdy",  arb.a_cmd_ready, 0);
      check("rst_b_rdy",  arb.b_cmd_ready, 0);
      check("rst_ram_en", arb.ram_en, 0);
      check("rst_ram_wr", arb.ram_wr, 0);
      check("rst_a_rspv", arb.a_rsp_valid, 0);
      check("rst_b_rspv", arb.b_rsp_valid, 0);
      check("rst_err",    arb.rom_wr_err, 0);
      check("rst_cnt",    arb.rom_wr_err_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;
      idle();

      // ---- both ports read continuously: A,B,A,B,A,B
      aa = 12'h010;
      ba = 12'h020;
      a_turn = 1'b1;
      last_a = 1'b0;
      last_addr = '0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 6) begin
            cmd_a(1'b1, 1'b0, aa, 4'h0, 32'h0);
            cmd_b(1'b1, 1'b0, ba, 4'h0, 32'h0);
         end else begin
            idle();
         end
         #1;
         if (i > 0) begin
            check("alt_rsp_a_v", arb.a_rsp_valid, last_a);
            check("alt_rsp_b_v", arb.b_rsp_valid, !last_a);
            check("alt_rsp_data", last_a ? arb.a_rsp_data : arb.b_rsp_data, pat(last_addr));
         end
         if (i < 6) begin
            check("alt_rdy_a",  arb.a_cmd_ready, a_turn);
            check("alt_rdy_b",  arb.b_cmd_ready, !a_turn);
            check("alt_ram_en", arb.ram_en, 1);
            check("alt_addr",   arb.ram_addr, a_turn ? aa : ba);
            last_a    = a_turn;
            last_addr = a_turn ? aa : ba;
            if (a_turn) aa++;
            else        ba++;
            a_turn = !a_turn;
         end
      end

      // ---- single A read of word 0
      @(negedge clk);
      cmd_a(1'b1, 1'b0, 12'h000, 4'h0, 32'h0);
      #1;
      check("rd0_a_rdy", arb.a_cmd_ready, 1);
      check("rd0_b_rdy", arb.b_cmd_ready, 0);
      check("rd0_addr",  arb.ram_addr, 12'h000);
      @(negedge clk);
      idle();
      #1;
      check("rd0_rspv",  arb.a_rsp_valid, 1);
      check("rd0_data",  arb.a_rsp_data, 32'h12345678);
      check("rd0_b_rspv", arb.b_rsp_valid, 0);

      // ---- write-then-read same word: one bubble
      @(negedge clk);
      cmd_b(1'b1, 1'b1, 12'h400, 4'hF, 32'hDEADBEEF);
      #1;
      check("haz_wr_rdy", arb.b_cmd_ready, 1);
      check("haz_ram_wr", arb.ram_wr, 1);
      @(negedge clk);
      idle();
      cmd_a(1'b1, 1'b0, 12'h400, 4'h0, 32'h0);
      #1;
      check("haz_bub_a_rdy", arb.a_cmd_ready, 0);
      check("haz_bub_b_rdy", arb.b_cmd_ready, 0);
      check("haz_bub_en",    arb.ram_en, 0);
      @(negedge clk);
      #1;
      check("haz_rd_rdy", arb.a_cmd_ready, 1);
      check("haz_rd_en",  arb.ram_en, 1);
      @(negedge clk);
      idle();
      #1;
      check("haz_rspv", arb.a_rsp_valid, 1);
      check("haz_data", arb.a_rsp_data, 32'hDEADBEEF);

      // ---- write then read of a different word: no bubble
      @(negedge clk);
      cmd_b(1'b1, 1'b1, 12'h401, 4'hF, 32'hCAFEF00D);
      #1;
      check("diff_ram_wr", arb.ram_wr, 1);
      @(negedge clk);
      idle();
      cmd_a(1'b1, 1'b0, 12'h402, 4'h0, 32'h0);
      #1;
      check("diff_rd_rdy", arb.a_cmd_ready, 1);
      @(negedge clk);
      idle();
      #1;
      check("diff_data", arb.a_rsp_data, pat(12'h402));
      check("diff_mem",  mem[12'h401], 32'hCAFEF00D);

      // ---- 300 writes to the last ROM word
      n_rdy = 0;
      n_pulse = 0;
      n_ramwr = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cmd_a(1'b1, 1'b1, 12'h3FF, 4'hF, 32'hFFFFFFFF);
         #1;
         n_rdy   += int'(arb.a_cmd_ready);
         n_pulse += int'(arb.rom_wr_err);
         n_ramwr += int'(arb.ram_wr);
         if (i == 1)   check("rom_cnt_1",   arb.rom_wr_err_cnt, 1);
         if (i == 254) check("rom_cnt_254", arb.rom_wr_err_cnt, 254);
         if (i == 255) check("rom_cnt_255", arb.rom_wr_err_cnt, 255);
         if (i == 299) check("rom_cnt_sat", arb.rom_wr_err_cnt, 255);
      end
      // dropped writes leave no hazard: the read goes straight through
      @(negedge clk);
      cmd_a(1'b1, 1'b0, 12'h3FF, 4'h0, 32'h0);
      #1;
      check("rom_n_rdy",   n_rdy, 300);
      check("rom_n_pulse", n_pulse, 300);
      check("rom_n_ramwr", n_ramwr, 0);
      check("rom_rd_rdy",  arb.a_cmd_ready, 1);
      check("rom_rd_err",  arb.rom_wr_err, 0);
      check("rom_cnt_end", arb.rom_wr_err_cnt, 255);
      @(negedge clk);
      idle();
      #1;
      check("rom_rd_data", arb.a_rsp_data, pat(12'h3FF));

      // ---- byte-masked write over 0x11223344
      @(negedge clk);
      cmd_b(1'b1, 1'b1, 12'h400, 4'hF, 32'h11223344);
      @(negedge clk);
      cmd_b(1'b1, 1'b1, 12'h400, 4'b0010, 32'h0000AB00);
      #1;
      check("mask_wr_rdy", arb.b_cmd_ready, 1);
      @(negedge clk);
      idle();
      cmd_a(1'b1, 1'b0, 12'h400, 4'h0, 32'h0);
      #1;
      check("mask_bub", arb.a_cmd_ready, 0);
      @(negedge clk);
      #1;
      check("mask_rd_rdy", arb.a_cmd_ready, 1);
      @(negedge clk);
      idle();
      #1;
      check("mask_data", arb.a_rsp_data, 32'h1122AB44);

      // ---- top word 0xFFF is ordinary RAM
      @(negedge clk);
      cmd_b(1'b1, 1'b1, 12'hFFF, 4'hF, 32'h0F0F0F0F);
      #1;
      check("fff_ram_wr", arb.ram_wr, 1);
      check("fff_addr",   arb.ram_addr, 12'hFFF);
      @(negedge clk);
      idle();
      @(negedge clk);
      cmd_b(1'b1, 1'b0, 12'hFFF, 4'h0, 32'h0);
      #1;
      check("fff_rd_rdy", arb.b_cmd_ready, 1);
      @(negedge clk);
      idle();
      #1;
      check("fff_rspv", arb.b_rsp_valid, 1);
      check("fff_data", arb.b_rsp_data, 32'h0F0F0F0F);

      // ---- reset right after an accepted A read
      @(negedge clk);
      cmd_a(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
      #1;
      check("mr_a_rdy", arb.a_cmd_ready, 1);
      @(negedge clk);
      reset_n = 1'b0;
      cmd_a(1'b1, 1'b0, 12'h011, 4'h0, 32'h0);
      cmd_b(1'b1, 1'b0, 12'h021, 4'h0, 32'h0);
      #1;
      check("mr_a_rspv",  arb.a_rsp_valid, 0);
      check("mr_a_rspd",  arb.a_rsp_data, 0);
      check("mr_b_rspv",  arb.b_rsp_valid, 0);
      check("mr_a_rdy0",  arb.a_cmd_ready, 0);
      check("mr_b_rdy0",  arb.b_cmd_ready, 0);
      check("mr_ram_en",  arb.ram_en, 0);
      check("mr_ram_wr",  arb.ram_wr, 0);
      check("mr_err",     arb.rom_wr_err, 0);
      check("mr_cnt",     arb.rom_wr_err_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("mr_tie_a",   arb.a_cmd_ready, 1);
      check("mr_tie_b",   arb.b_cmd_ready, 0);
      check("mr_no_rsp",  arb.a_rsp_valid, 0);
      @(negedge clk);
      idle();
      #1;
      check("mr_rspv",    arb.a_rsp_valid, 1);
      check("mr_data",    arb.a_rsp_data, pat(12'h011));
      check("mr_b_rspv2", arb.b_rsp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
